// File: rtl/adder_tb_pkg.sv
// Shared constants for the adder self-check engine: FSM encoding, LFSR
// polynomial, default seed and stimulus mode values.
package adder_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Taps for x^32+x^22+x^2+x+1 in right-shifting Galois form.
    localparam logic [31:0] LFSR_POLY         = 32'h80200003;
    localparam logic [31:0] LFSR_DEFAULT_SEED = 32'h1;

    localparam logic MODE_RAND = 1'b0;
    localparam logic MODE_WALK = 1'b1;

    // One Galois step: shift right, fold the polynomial in when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        lfsr_step = l[0] ? ((l >> 1) ^ LFSR_POLY) : (l >> 1);
    endfunction

endpackage

// File: rtl/adder_selfcheck_engine_if.sv
// Operand/result bus between the self-check engine and the adder under test.
// Bus protocol: there is no valid/ready pair. While the engine is busy it
// presents one new a/b/cin vector per cycle and the adder must answer with
// s/cout/prop/gen exactly LAT cycles later; there is no backpressure.
interface adder_selfcheck_engine_if #(
    parameter int N = 64
);
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s_duv;
    logic         cout_duv;
    logic         prop_duv;
    logic         gen_duv;

    modport master (
        output a, b, cin,
        input  s_duv, cout_duv, prop_duv, gen_duv
    );

    modport slave (
        input  a, b, cin,
        output s_duv, cout_duv, prop_duv, gen_duv
    );
endinterface

// File: rtl/adder_exp_pipe.sv
// Latency-matching shift register for expected results. Valid bits are
// reset; data bits are only qualified by valid and carry no reset.
module adder_exp_pipe #(
    parameter int W   = 8,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_v,
    input  logic [W-1:0] in_d,
    output logic         out_v,
    output logic [W-1:0] out_d
);
    generate
        if (LAT == 0) begin : g_bypass
            // Combinational DUV: compare in the issue cycle.
            logic unused_clk_rst;
            assign unused_clk_rst = ^{clk, rst};
            assign out_v = in_v;
            assign out_d = in_d;
        end else begin : g_pipe
            logic [LAT-1:0] v_q;
            logic [W-1:0]   d_q [LAT];

            // Valid chain; cleared on reset so an aborted run leaves no entries.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= '0;
                end else begin
                    v_q[0] <= in_v;
                    for (int i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
                end
            end

            // Data chain shifts alongside the valid chain.
            always_ff @(posedge clk) begin
                d_q[0] <= in_d;
                for (int i = 1; i < LAT; i++) d_q[i] <= d_q[i-1];
            end

            assign out_v = v_q[LAT-1];
            assign out_d = d_q[LAT-1];
        end
    endgenerate
endmodule

// File: rtl/adder_selfcheck_engine.sv
// Self-check engine: issues operand vectors to an adder, carries the
// expected results through a latency-matched pipe, counts mismatches and
// records the first failing vector.
module adder_selfcheck_engine
    import adder_tb_pkg::*;
#(
    parameter int N        = 64,
    parameter int LAT      = 0,
    parameter int CHECK_PG = 1,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    input  logic [31:0]              seed,
    input  logic [CNT_W-1:0]         num_vec,
    adder_selfcheck_engine_if.master duv,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [CNT_W-1:0]         err_cnt,
    output logic [CNT_W-1:0]         fail_idx,
    output logic [N-1:0]             fail_a,
    output logic [N-1:0]             fail_b,
    output logic                     fail_cin,
    output state_t                   state_dbg
);
    localparam int W = CNT_W + 3*N + 4;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] num_q, k_q, vec_k_q;
    logic             mode_q, walk_cin_q, cin_q, vec_v_q;
    logic [31:0]      lfsr_q;
    logic [N-1:0]     walk_b_q, a_q, b_q, rand_a, rand_b;
    logic [3:0]       drain_q;
    logic [N:0]       sum_ref, ab_ref;
    logic             accept, exp_v, mismatch;
    logic [W-1:0]     exp_d;
    logic [CNT_W-1:0] e_k, err_next;
    logic [N-1:0]     e_a, e_b, e_s;
    logic             e_cin, e_cout, e_prop, e_gen;

    assign accept    = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;
    assign duv.a     = a_q;
    assign duv.b     = b_q;
    assign duv.cin   = cin_q;

    // Random operands: LFSR word and its bit-reverse, repeated LSB-first.
    always_comb begin
        rand_a = '0;
        rand_b = '0;
        for (int i = 0; i < N; i++) begin
            rand_a[i] = lfsr_q[i % 32];
            rand_b[i] = lfsr_q[31 - (i % 32)];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: if (start) state_d = (num_vec == '0) ? ST_DONE : ST_RUN;
            ST_RUN:           if (k_q == num_q - CNT_W'(1)) state_d = ST_DRAIN;
            ST_DRAIN:         if (drain_q == 4'(LAT)) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Vector generation: load run parameters on start, issue one vector per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            num_q <= '0; k_q <= '0; vec_k_q <= '0; mode_q <= MODE_RAND;
            lfsr_q <= LFSR_DEFAULT_SEED; walk_b_q <= '0; walk_cin_q <= 1'b0;
            drain_q <= '0; a_q <= '0; b_q <= '0; cin_q <= 1'b0; vec_v_q <= 1'b0;
        end else begin
            vec_v_q <= 1'b0;
            if (accept) begin
                mode_q     <= mode;
                num_q      <= num_vec;
                lfsr_q     <= (seed == 32'd0) ? LFSR_DEFAULT_SEED : seed;
                walk_b_q   <= N'(1);
                walk_cin_q <= 1'b0;
                k_q        <= '0;
                drain_q    <= '0;
            end else if (state_q == ST_RUN) begin
                a_q        <= (mode_q == MODE_WALK) ? '1 : rand_a;
                b_q        <= (mode_q == MODE_WALK) ? walk_b_q : rand_b;
                cin_q      <= (mode_q == MODE_WALK) ? walk_cin_q : lfsr_q[31];
                vec_v_q    <= 1'b1;
                vec_k_q    <= k_q;
                k_q        <= k_q + CNT_W'(1);
                lfsr_q     <= lfsr_step(lfsr_q);
                // The walking one wraps every N vectors, flipping cin each wrap.
                walk_b_q   <= {walk_b_q[N-2:0], walk_b_q[N-1]};
                if (walk_b_q[N-1]) walk_cin_q <= ~walk_cin_q;
            end else if (state_q == ST_DRAIN) begin
                drain_q    <= drain_q + 4'd1;
            end
        end
    end

    // Reference results for the vector currently on the bus.
    always_comb begin
        sum_ref = {1'b0, a_q} + {1'b0, b_q} + {{N{1'b0}}, cin_q};
        ab_ref  = {1'b0, a_q} + {1'b0, b_q};
    end

    adder_exp_pipe #(.W(W), .LAT(LAT)) u_pipe (
        .clk   (clk),
        .rst   (rst),
        .in_v  (vec_v_q),
        .in_d  ({vec_k_q, a_q, b_q, cin_q, sum_ref, &(a_q ^ b_q), ab_ref[N]}),
        .out_v (exp_v),
        .out_d (exp_d)
    );

    assign {e_k, e_a, e_b, e_cin, e_cout, e_s, e_prop, e_gen} = exp_d;

    // Compare the emerging expected entry against the DUV answer.
    always_comb begin
        mismatch = exp_v && ((duv.s_duv != e_s) || (duv.cout_duv != e_cout) ||
                   ((CHECK_PG != 0) && ((duv.prop_duv != e_prop) || (duv.gen_duv != e_gen))));
        err_next = (mismatch && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;
    end

    // Error counter, first-failure capture and the final pass flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0; fail_idx <= '0; fail_a <= '0; fail_b <= '0;
            fail_cin <= 1'b0; pass <= 1'b0;
        end else if (accept) begin
            err_cnt <= '0; fail_idx <= '0; fail_a <= '0; fail_b <= '0;
            fail_cin <= 1'b0; pass <= (num_vec == '0);
        end else begin
            err_cnt <= err_next;
            if (mismatch && (err_cnt == '0)) begin
                fail_idx <= e_k;
                fail_a   <= e_a;
                fail_b   <= e_b;
                fail_cin <= e_cin;
            end
            if (state_q == ST_DRAIN && state_d == ST_DONE) pass <= (err_next == '0);
        end
    end
endmodule

// File: tb/tb_adder_selfcheck_engine.sv
// Bench for adder_selfcheck_engine: four engine instances with different
// width/latency/check settings, each driving a behavioural adder with
// optional planted faults, checked against a vector-level reference model.
module tb_adder_selfcheck_engine;
    import adder_tb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  start_v;
    logic        mode;
    logic [31:0] seed;
    logic [31:0] num_vec;
    logic        fault_s5, fault_gen;
    int          n_cmp, n_err;

    // Clock.
    always #5 clk = ~clk;

    adder_selfcheck_engine_if #(.N(8))  if0 ();
    adder_selfcheck_engine_if #(.N(64)) if1 ();
    adder_selfcheck_engine_if #(.N(16)) if2 ();
    adder_selfcheck_engine_if #(.N(8))  if3 ();

    logic [3:0]       busy_w, done_w, pass_w, fcin_w;
    logic [3:0][31:0] err_w, fidx_w;
    logic [3:0][1:0]  st_w;
    logic [7:0]       fa0, fb0, fa3, fb3;
    logic [63:0]      fa1, fb1;
    logic [15:0]      fa2, fb2;

    adder_selfcheck_engine #(.N(8), .LAT(0), .CHECK_PG(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode), .seed(seed), .num_vec(num_vec),
        .duv(if0.master), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]), .err_cnt(err_w[0]),
        .fail_idx(fidx_w[0]), .fail_a(fa0), .fail_b(fb0), .fail_cin(fcin_w[0]), .state_dbg(st_w[0]));
    adder_selfcheck_engine #(.N(64), .LAT(3), .CHECK_PG(1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode), .seed(seed), .num_vec(num_vec),
        .duv(if1.master), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]), .err_cnt(err_w[1]),
        .fail_idx(fidx_w[1]), .fail_a(fa1), .fail_b(fb1), .fail_cin(fcin_w[1]), .state_dbg(st_w[1]));
    adder_selfcheck_engine #(.N(16), .LAT(2), .CHECK_PG(1)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode), .seed(seed), .num_vec(num_vec),
        .duv(if2.master), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]), .err_cnt(err_w[2]),
        .fail_idx(fidx_w[2]), .fail_a(fa2), .fail_b(fb2), .fail_cin(fcin_w[2]), .state_dbg(st_w[2]));
    adder_selfcheck_engine #(.N(8), .LAT(0), .CHECK_PG(0)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode), .seed(seed), .num_vec(num_vec),
        .duv(if3.master), .busy(busy_w[3]), .done(done_w[3]), .pass(pass_w[3]), .err_cnt(err_w[3]),
        .fail_idx(fidx_w[3]), .fail_a(fa3), .fail_b(fb3), .fail_cin(fcin_w[3]), .state_dbg(st_w[3]));

    // Behavioural adders. u0/u3: combinational, gen may be tied low.
    logic [8:0] s0, ab0, s3, ab3;
    logic [64:0] s1, ab1;
    logic [16:0] s2, ab2;
    always_comb begin
        s0  = {1'b0, if0.a} + {1'b0, if0.b} + 9'(if0.cin);
        ab0 = {1'b0, if0.a} + {1'b0, if0.b};
        s3  = {1'b0, if3.a} + {1'b0, if3.b} + 9'(if3.cin);
        ab3 = {1'b0, if3.a} + {1'b0, if3.b};
        s1  = {1'b0, if1.a} + {1'b0, if1.b} + 65'(if1.cin);
        ab1 = {1'b0, if1.a} + {1'b0, if1.b};
        s2  = {1'b0, if2.a} + {1'b0, if2.b} + 17'(if2.cin);
        ab2 = {1'b0, if2.a} + {1'b0, if2.b};
    end
    assign {if0.cout_duv, if0.s_duv} = s0;
    assign if0.prop_duv = &(if0.a ^ if0.b);
    assign if0.gen_duv  = ab0[8] & ~fault_gen;
    assign {if3.cout_duv, if3.s_duv} = s3;
    assign if3.prop_duv = &(if3.a ^ if3.b);
    assign if3.gen_duv  = ab3[8] & ~fault_gen;

    // u1: ideal 3-cycle pipelined adder; u2: 2-cycle adder with s[5] optionally stuck at 0.
    logic [67:0] p1 [3];
    logic [18:0] p2 [2];
    always @(posedge clk) begin
        p1[0] <= {s1, &(if1.a ^ if1.b), ab1[64]};
        p1[1] <= p1[0];
        p1[2] <= p1[1];
        p2[0] <= {s2[16:6], s2[5] & ~fault_s5, s2[4:0], &(if2.a ^ if2.b), ab2[16]};
        p2[1] <= p2[0];
    end
    assign {if1.cout_duv, if1.s_duv, if1.prop_duv, if1.gen_duv} = p1[2];
    assign {if2.cout_duv, if2.s_duv, if2.prop_duv, if2.gen_duv} = p2[1];

    // Monitor mux: view of the instance under test.
    logic [1:0]   sel;
    logic         mon_busy, mon_done, mon_pass, mon_cin, mon_fcin;
    logic [31:0]  mon_err, mon_fidx;
    logic [1:0]   mon_state;
    logic [255:0] mon_a, mon_b, mon_fa, mon_fb;
    always_comb begin
        mon_busy  = busy_w[sel];
        mon_done  = done_w[sel];
        mon_pass  = pass_w[sel];
        mon_fcin  = fcin_w[sel];
        mon_err   = err_w[sel];
        mon_fidx  = fidx_w[sel];
        mon_state = st_w[sel];
        case (sel)
            2'd0:    begin mon_a = 256'(if0.a); mon_b = 256'(if0.b); mon_cin = if0.cin; mon_fa = 256'(fa0); mon_fb = 256'(fb0); end
            2'd1:    begin mon_a = 256'(if1.a); mon_b = 256'(if1.b); mon_cin = if1.cin; mon_fa = 256'(fa1); mon_fb = 256'(fb1); end
            2'd2:    begin mon_a = 256'(if2.a); mon_b = 256'(if2.b); mon_cin = if2.cin; mon_fa = 256'(fa2); mon_fb = 256'(fb2); end
            default: begin mon_a = 256'(if3.a); mon_b = 256'(if3.b); mon_cin = if3.cin; mon_fa = 256'(fa3); mon_fb = 256'(fb3); end
        endcase
    end

    // Scoreboard: expected issue order of operands.
    logic [255:0] exp_q[$];
    logic [255:0] exp_b_q[$];
    logic         exp_c_q[$];

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int n_of(input int s);
        case (s) 0: return 8; 1: return 64; 2: return 16; default: return 8; endcase
    endfunction
    function automatic int lat_of(input int s);
        case (s) 1: return 3; 2: return 2; default: return 0; endcase
    endfunction
    function automatic bit pg_of(input int s);
        return (s != 3);
    endfunction

    function automatic logic [31:0] galois_next(input logic [31:0] l);
        logic [31:0] r;
        r = l >> 1;
        if (l[0]) r = r ^ 32'h80200003;
        return r;
    endfunction

    // Driver + model for one complete run on instance s.
    task automatic run_case(input string tag, input int s, input logic md, input logic [31:0] sd,
                            input int num, input bit fs5, input bit fgen, input bit poke);
        int n, lat, busy_cnt, idx, exp_err, exp_fidx;
        bit pg, bad;
        logic [31:0] l;
        logic [255:0] va, vb, m, exp_fa, exp_fb;
        logic vc, exp_fc;
        logic [256:0] sum, ab;
        n = n_of(s); lat = lat_of(s); pg = pg_of(s);
        m = (256'(1) << n) - 256'(1);
        l = (sd == 32'd0) ? 32'd1 : sd;
        exp_q.delete(); exp_b_q.delete(); exp_c_q.delete();
        exp_err = 0; exp_fidx = 0; exp_fa = '0; exp_fb = '0; exp_fc = 1'b0;
        for (int k = 0; k < num; k++) begin
            va = '0; vb = '0;
            if (md == MODE_RAND) begin
                for (int i = 0; i < n; i++) begin
                    va[i] = l[i % 32];
                    vb[i] = l[31 - (i % 32)];
                end
                vc = l[31];
                l = galois_next(l);
            end else begin
                va = m;
                vb = 256'(1) << (k % n);
                vc = ((k / n) % 2) == 1;
            end
            sum = {1'b0, va} + {1'b0, vb} + 257'(vc);
            ab  = {1'b0, va} + {1'b0, vb};
            bad = (fs5 && sum[5]) || (fgen && pg && ab[n]);
            if (bad) begin
                if (exp_err == 0) begin exp_fidx = k; exp_fa = va; exp_fb = vb; exp_fc = vc; end
                exp_err++;
            end
            exp_q.push_back(va); exp_b_q.push_back(vb); exp_c_q.push_back(vc);
        end
        sel = 2'(s); fault_s5 = fs5; fault_gen = fgen;
        @(negedge clk);
        mode = md; seed = sd; num_vec = 32'(num); start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        busy_cnt = 0;
        while (mon_busy && busy_cnt < num + lat + 20) begin
            busy_cnt++;
            if (poke && busy_cnt == 5) begin start_v[s] = 1'b1; num_vec = 32'd3; mode = ~md; end
            @(negedge clk);
            start_v[s] = 1'b0; num_vec = 32'(num); mode = md;
            idx = busy_cnt - 1;
            if (idx < num) begin
                chk({tag, "_a"},   mon_a,          exp_q.pop_front());
                chk({tag, "_b"},   mon_b,          exp_b_q.pop_front());
                chk({tag, "_cin"}, 256'(mon_cin),  256'(exp_c_q.pop_front()));
            end
        end
        chk({tag, "_busy_cycles"}, 256'(busy_cnt), 256'(num + lat + 1));
        chk({tag, "_done"},     256'(mon_done),  256'(1));
        chk({tag, "_state"},    256'(mon_state), 256'(ST_DONE));
        chk({tag, "_pass"},     256'(mon_pass),  256'(exp_err == 0));
        chk({tag, "_err_cnt"},  256'(mon_err),   256'(exp_err));
        chk({tag, "_fail_idx"}, 256'(mon_fidx),  256'(exp_fidx));
        chk({tag, "_fail_a"},   mon_fa,          exp_fa);
        chk({tag, "_fail_b"},   mon_fb,          exp_fb);
        chk({tag, "_fail_cin"}, 256'(mon_fcin),  256'(exp_fc));
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_state"}, 256'(mon_state), 256'(ST_IDLE));
        chk({tag, "_a"},     mon_a,           256'(0));
        chk({tag, "_b"},     mon_b,           256'(0));
        chk({tag, "_cin"},   256'(mon_cin),   256'(0));
        chk({tag, "_busy"},  256'(mon_busy),  256'(0));
        chk({tag, "_done"},  256'(mon_done),  256'(0));
        chk({tag, "_pass"},  256'(mon_pass),  256'(0));
        chk({tag, "_err"},   256'(mon_err),   256'(0));
        chk({tag, "_fidx"},  256'(mon_fidx),  256'(0));
        chk({tag, "_fa"},    mon_fa,          256'(0));
    endtask

    // Watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Directed sequence.
    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1; start_v = '0; mode = MODE_RAND; seed = '0; num_vec = '0;
        fault_s5 = 1'b0; fault_gen = 1'b0; sel = 2'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sel = 2'(i);
            #1;
            chk_cleared("reset");
        end
        @(negedge clk);
        rst = 1'b0;

        run_case("walk8",       0, MODE_WALK, 32'd0,     16,                      1'b0, 1'b0, 1'b0);
        run_case("rand64_s0",   1, MODE_RAND, 32'd0,     1000,                    1'b0, 1'b0, 1'b0);
        run_case("rand64",      1, MODE_RAND, $urandom,  $urandom_range(60, 200), 1'b0, 1'b0, 1'b0);
        run_case("s5_walk",     2, MODE_WALK, 32'd0,     32,                      1'b1, 1'b0, 1'b0);
        run_case("s5_rand",     2, MODE_RAND, $urandom,  100,                     1'b1, 1'b0, 1'b0);
        run_case("gen_pg1",     0, MODE_WALK, 32'd0,     8,                       1'b0, 1'b1, 1'b0);
        run_case("gen_pg0",     3, MODE_WALK, 32'd0,     8,                       1'b0, 1'b1, 1'b0);
        run_case("gen_rand",    0, MODE_RAND, $urandom,  60,                      1'b0, 1'b1, 1'b0);
        run_case("start_busy",  2, MODE_WALK, 32'd0,     40,                      1'b1, 1'b0, 1'b1);

        // Abort a faulty run around vector 10 with reset.
        sel = 2'd2; fault_s5 = 1'b1;
        @(negedge clk);
        mode = MODE_WALK; seed = '0; num_vec = 32'd32; start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_cleared("mid_rst");
        rst = 1'b0;

        // Zero-length run goes straight to DONE with pass set.
        num_vec = 32'd0; start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        chk("zero_done",  256'(mon_done),  256'(1));
        chk("zero_busy",  256'(mon_busy),  256'(0));
        chk("zero_pass",  256'(mon_pass),  256'(1));
        chk("zero_state", 256'(mon_state), 256'(ST_DONE));
        chk("zero_err",   256'(mon_err),   256'(0));

        run_case("after_rst",   2, MODE_WALK, 32'd0,     20,                      1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
